if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter NBITS, default 32, datapath and PC width.
REQ-002 Parameter HALT_WORD, default 32'hFFFFFFFF, instruction encoding that stops fetch.
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 i_step  in  1  advance enable; when 0, all state holds (debug stepping).
REQ-006 i_stall  in  1  load-use stall from hazard unit; hold PC and IF/ID.
REQ-007 i_branch_taken  in  1  taken branch resolved in EX.
REQ-008 i_branch_target  in  NBITS  branch destination.
REQ-009 i_jump  in  1  J/JAL decoded in ID.
REQ-010 i_jump_target  in  NBITS  J/JAL destination.
REQ-011 i_jr  in  1  JR/JALR decoded in ID.
REQ-012 i_jr_target  in  NBITS  register destination (rs value).
REQ-013 i_instruction  in  NBITS  instruction memory read data for o_pc (combinational read).
REQ-014 o_pc  out  NBITS  current fetch address to instruction memory.
REQ-015 o_pc4  out  NBITS  IF/ID: fetch address + 4 of latched instruction.
REQ-016 o_pc8  out  NBITS  IF/ID: fetch address + 8 (link value for JAL/JALR).
REQ-017 o_instruction  out  NBITS  IF/ID: latched instruction, NOP (all zero) when invalid.
REQ-018 o_valid  out  1  IF/ID holds a real fetched instruction.
REQ-019 o_flush  out  1  combinational; redirect accepted this cycle, drives ID/EX flush.
REQ-020 o_halted  out  1  fetch FSM in HALTED.
REQ-021 o_fetch_count  out  NBITS  number of instructions latched valid into IF/ID.

Function
REQ-022 FSM states RUN and HALTED; no other state reachable.
REQ-023 Redirect priority: i_branch_taken > i_jr > i_jump; a lower-priority request in the same cycle is ignored.
REQ-024 i_jr and i_jump are ignored while i_stall=1; i_branch_taken is honoured regardless of i_stall.
REQ-025 o_flush = i_step & accepted redirect; 0 otherwise.
REQ-026 Accepted redirect (i_step=1): PC <= selected target; IF/ID <= NOP, o_valid <= 0; state <= RUN (cancels a speculative HALT); count unchanged.
REQ-027 No redirect, i_stall=1, i_step=1: PC, IF/ID, state, count hold.
REQ-028 RUN, no redirect, no stall, i_step=1, i_instruction != HALT_WORD: PC <= PC+4; IF/ID <= {PC+4, PC+8, i_instruction}; o_valid <= 1; count +1.
REQ-029 RUN, same conditions, i_instruction == HALT_WORD: IF/ID latches HALT with o_valid=1, count +1, PC holds, state <= HALTED.
REQ-030 HALTED, no redirect, i_step=1: PC holds; IF/ID <= NOP, o_valid <= 0; count holds.
REQ-031 i_step=0: no state changes regardless of other inputs; o_flush=0.
REQ-032 PC and PC+4/PC+8 arithmetic modulo 2^NBITS; 0xFFFFFFFC+4 wraps to 0.
REQ-033 o_fetch_count wraps from all-ones to 0.
REQ-034 Targets used as given; low two bits are not masked or checked.
REQ-035 Latency: an instruction presented at o_pc appears on o_instruction one accepted step later.

Reset
REQ-036 i_reset=1 on a rising edge, overriding i_step and all other inputs: o_pc=0, o_pc4=0, o_pc8=0, o_instruction=0, o_valid=0, o_halted=0, o_fetch_count=0, state RUN.
REQ-037 Reset mid-HALT or mid-stall returns to RUN at PC 0 on the next edge; o_flush is 0 while i_reset=1.

Verification
REQ-038 Reset, then 3 steps with words A,B,C -> o_pc 0,4,8,12; last o_instruction=C, o_pc4=12, o_pc8=16, o_fetch_count=3.
REQ-039 i_stall=1 for 2 steps at PC 8 -> o_pc stays 8, IF/ID and count unchanged; release resumes at 8 -> 12.
REQ-040 Same cycle i_branch_taken target 0x40, i_jr target 0x80, i_jump target 0xC0 -> o_flush=1, o_pc=0x40, o_valid=0.
REQ-041 HALT_WORD fetched at PC 0x20 -> o_halted=1, o_pc stays 0x20, IF/ID=HALT then NOP; later i_branch_taken to 0x10 -> o_halted=0, o_pc=0x10.
REQ-042 i_jump=1 with i_stall=1 -> jump ignored, o_flush=0; i_step=0 with i_branch_taken=1 -> no change.
REQ-043 PC forced to 0xFFFFFFFC via branch, one step -> o_pc=0, o_pc4=0, o_pc8=4.

Source files
------------

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage with an IF/ID pipeline register.
//
// The stage keeps the fetch PC. It picks the next PC from the redirect
// sources or from sequential fetch, and latches each fetched word into IF/ID.
// A two-state FSM (RUN / HALTED) stops sequential fetch once HALT_WORD has
// been latched. Any accepted redirect returns the FSM to RUN.
//
// Ports:
//   i_clk, i_reset          clock; synchronous active-high reset
//   i_step                  advance enable; 0 freezes all state
//   i_stall                 hold PC and IF/ID (load-use hazard)
//   i_branch_taken/_target  redirect from EX (highest priority)
//   i_jr/_target            redirect from ID, register target
//   i_jump/_target          redirect from ID, immediate target (lowest)
//   i_instruction           instruction memory read data for o_pc
//   o_pc                    current fetch address
//   o_pc4, o_pc8            IF/ID: fetch address +4 / +8 (link value)
//   o_instruction, o_valid  IF/ID: latched word (all zero = NOP when invalid)
//   o_flush                 redirect accepted this cycle (flushes ID/EX)
//   o_halted                FSM state: 1 = HALTED
//   o_fetch_count           count of words latched valid into IF/ID
// ---------------------------------------------------------------------------
module if_stage #(
  parameter int                NBITS     = 32,
  parameter logic [NBITS-1:0]  HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_step,
  input  logic             i_stall,
  input  logic             i_branch_taken,
  input  logic [NBITS-1:0] i_branch_target,
  input  logic             i_jump,
  input  logic [NBITS-1:0] i_jump_target,
  input  logic             i_jr,
  input  logic [NBITS-1:0] i_jr_target,
  input  logic [NBITS-1:0] i_instruction,
  output logic [NBITS-1:0] o_pc,
  output logic [NBITS-1:0] o_pc4,
  output logic [NBITS-1:0] o_pc8,
  output logic [NBITS-1:0] o_instruction,
  output logic             o_valid,
  output logic             o_flush,
  output logic             o_halted,
  output logic [NBITS-1:0] o_fetch_count
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] pc_q, pc_d;
  logic [NBITS-1:0] pc4_q, pc4_d;
  logic [NBITS-1:0] pc8_q, pc8_d;
  logic [NBITS-1:0] instr_q, instr_d;
  logic [NBITS-1:0] count_q, count_d;
  logic             valid_q, valid_d;

  logic             redirect;
  logic [NBITS-1:0] target;
  logic [NBITS-1:0] pc_plus4;
  logic [NBITS-1:0] pc_plus8;

  // Wrap modulo 2^NBITS.
  assign pc_plus4 = pc_q + NBITS'(4);
  assign pc_plus8 = pc_q + NBITS'(8);

  // Redirect select. The EX branch outranks a stall because the stalled
  // instruction is on the wrong path anyway. The ID-stage JR and jump are only
  // valid once their instruction leaves ID, so a stall suppresses them.
  always_comb begin
    redirect = 1'b0;
    target   = pc_q;
    if (i_branch_taken) begin
      redirect = 1'b1;
      target   = i_branch_target;
    end else if (!i_stall && i_jr) begin
      redirect = 1'b1;
      target   = i_jr_target;
    end else if (!i_stall && i_jump) begin
      redirect = 1'b1;
      target   = i_jump_target;
    end
  end

  assign o_flush = i_step & redirect & ~i_reset;

  // Next-state and IF/ID update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    pc8_d   = pc8_q;
    instr_d = instr_q;
    valid_d = valid_q;
    count_d = count_q;
    if (i_step) begin
      if (redirect) begin
        // A redirect also cancels a HALT fetched down a wrong path.
        pc_d    = target;
        pc4_d   = '0;
        pc8_d   = '0;
        instr_d = '0;
        valid_d = 1'b0;
        state_d = RUN;
      end else if (i_stall) begin
        // Hold everything.
      end else if (state_q == RUN) begin
        pc4_d   = pc_plus4;
        pc8_d   = pc_plus8;
        instr_d = i_instruction;
        valid_d = 1'b1;
        count_d = count_q + NBITS'(1);
        if (i_instruction == HALT_WORD) begin
          // The HALT passes down the pipe. The PC stays on it, so a redirect
          // can still resume fetch.
          state_d = HALTED;
        end else begin
          pc_d = pc_plus4;
        end
      end else begin
        // HALTED: feed bubbles.
        pc4_d   = '0;
        pc8_d   = '0;
        instr_d = '0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= RUN;
      pc_q    <= '0;
      pc4_q   <= '0;
      pc8_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      pc8_q   <= pc8_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign o_pc          = pc_q;
  assign o_pc4         = pc4_q;
  assign o_pc8         = pc8_q;
  assign o_instruction = instr_q;
  assign o_valid       = valid_q;
  assign o_halted      = (state_q == HALTED);
  assign o_fetch_count = count_q;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- directed bench for if_stage.
// Each driven cycle pushes one hand-computed expectation. The expectation
// holds o_flush before the edge and the registered outputs after the edge.
// The monitor pops one entry per clock edge and compares each field.
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam int W = 32;
  localparam logic [W-1:0] HALT = 32'hFFFF_FFFF;

  logic         clk;
  logic         reset, step, stall, br, jr, jmp;
  logic [W-1:0] br_t, jr_t, jmp_t, instr;
  logic [W-1:0] pc, pc4, pc8, instr_o, count;
  logic         valid, flush, halted;

  if_stage #(.NBITS(W), .HALT_WORD(HALT)) dut (
    .i_clk(clk), .i_reset(reset), .i_step(step), .i_stall(stall),
    .i_branch_taken(br), .i_branch_target(br_t),
    .i_jump(jmp), .i_jump_target(jmp_t),
    .i_jr(jr), .i_jr_target(jr_t),
    .i_instruction(instr),
    .o_pc(pc), .o_pc4(pc4), .o_pc8(pc8), .o_instruction(instr_o),
    .o_valid(valid), .o_flush(flush), .o_halted(halted),
    .o_fetch_count(count)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard.
  typedef struct packed {
    logic         flush;
    logic [W-1:0] pc;
    logic [W-1:0] pc4;
    logic [W-1:0] pc8;
    logic [W-1:0] instr;
    logic         valid;
    logic         halted;
    logic [W-1:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor. o_flush depends only on inputs, so it is sampled at the edge.
  // Registered outputs are sampled 1 time unit after the edge.
  always begin
    logic f_s;
    exp_t e;
    @(posedge clk);
    f_s = flush;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("flush",  W'(f_s),    W'(e.flush));
      chk("pc",     pc,         e.pc);
      chk("valid",  W'(valid),  W'(e.valid));
      chk("halted", W'(halted), W'(e.halted));
      chk("count",  count,      e.count);
      chk("instr",  instr_o,    e.instr);
      if (e.valid) begin
        chk("pc4", pc4, e.pc4);
        chk("pc8", pc8, e.pc8);
      end
    end
  end

  // Driver tasks.
  task automatic clr();
    reset = 0; step = 1; stall = 0; br = 0; jr = 0; jmp = 0;
    br_t = '0; jr_t = '0; jmp_t = '0; instr = '0;
  endtask

  // Pushes the expectation for the cycle now set up and waits one cycle.
  task automatic cyc(input logic f, input logic [W-1:0] e_pc, input logic [W-1:0] e_pc4,
                     input logic [W-1:0] e_pc8, input logic [W-1:0] e_in,
                     input logic v, input logic h, input logic [W-1:0] c);
    exp_t e;
    e.flush = f; e.pc = e_pc; e.pc4 = e_pc4; e.pc8 = e_pc8;
    e.instr = e_in; e.valid = v; e.halted = h; e.count = c;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [W-1:0] A = 32'h1111_0001, B = 32'h2222_0002, C = 32'h3333_0003;
  localparam logic [W-1:0] D = 32'h4444_0004, E = 32'h5555_0005, F = 32'h6666_0006;
  localparam logic [W-1:0] G = 32'h7777_0007;

  initial begin
    // Reset overrides step and a taken branch; flush stays low.
    clr(); reset = 1; br = 1; br_t = 32'h40;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Sequential fetch A, B.
    clr(); instr = A; cyc(0, 32'h4, 32'h4, 32'h8, A, 1, 0, 1);
    clr(); instr = B; cyc(0, 32'h8, 32'h8, 32'hC, B, 1, 0, 2);

    // Stall at PC 8 for two steps, the second with a jump that is ignored.
    clr(); stall = 1; instr = C; cyc(0, 32'h8, 32'h8, 32'hC, B, 1, 0, 2);
    clr(); stall = 1; instr = C; jmp = 1; jmp_t = 32'h200;
    cyc(0, 32'h8, 32'h8, 32'hC, B, 1, 0, 2);

    // Step low: a branch and a new word change nothing.
    clr(); step = 0; br = 1; br_t = 32'h300; instr = D;
    cyc(0, 32'h8, 32'h8, 32'hC, B, 1, 0, 2);

    // Release: resume at 8 -> 12 with C.
    clr(); instr = C; cyc(0, 32'hC, 32'hC, 32'h10, C, 1, 0, 3);

    // All three redirects at once: the branch wins.
    clr(); br = 1; br_t = 32'h40; jr = 1; jr_t = 32'h80; jmp = 1; jmp_t = 32'hC0; instr = D;
    cyc(1, 32'h40, 0, 0, 0, 0, 0, 3);

    // JR beats jump.
    clr(); jr = 1; jr_t = 32'h1C; jmp = 1; jmp_t = 32'h90; instr = D;
    cyc(1, 32'h1C, 0, 0, 0, 0, 0, 3);

    // Fetch E, then HALT at 0x20.
    clr(); instr = E; cyc(0, 32'h20, 32'h20, 32'h24, E, 1, 0, 4);
    clr(); instr = HALT; cyc(0, 32'h20, 32'h24, 32'h28, HALT, 1, 1, 5);
    clr(); instr = A; cyc(0, 32'h20, 0, 0, 0, 0, 1, 5);
    clr(); instr = A; cyc(0, 32'h20, 0, 0, 0, 0, 1, 5);

    // A branch under stall is still honoured and leaves HALTED.
    clr(); stall = 1; br = 1; br_t = 32'h10; instr = HALT;
    cyc(1, 32'h10, 0, 0, 0, 0, 0, 5);
    clr(); instr = F; cyc(0, 32'h14, 32'h14, 32'h18, F, 1, 0, 6);

    // PC wrap at the top of the address space.
    clr(); br = 1; br_t = 32'hFFFF_FFFC; cyc(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 6);
    clr(); instr = G; cyc(0, 32'h0, 32'h0, 32'h4, G, 1, 0, 7);

    // Halt again, then reset mid-HALT with step low.
    clr(); instr = HALT; cyc(0, 32'h0, 32'h4, 32'h8, HALT, 1, 1, 8);
    clr(); reset = 1; step = 0; cyc(0, 0, 0, 0, 0, 0, 0, 0);
    clr(); instr = A; cyc(0, 32'h4, 32'h4, 32'h8, A, 1, 0, 1);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
